// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MCU IOBUS: byte FIFO, status/divisor readback.
// Optional completion interrupt is built in when UART_TX_IRQ_EN is defined.
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        INTR
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overrun_q, overrun_d;
    logic           irq_en_q, irq_en_d;
    logic           intr_q, intr_d;
    logic [15:0]    div_q, div_d;
    logic [15:0]    bit_len_q, bit_len_d;
    logic [15:0]    div_cnt_q, div_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;

    logic [29:0]    word_addr, base_word;
    logic           sel_data, sel_stat, sel_div;
    logic           wr_data, wr_stat, wr_div;
    logic           empty, full, push, pop, tc;
    logic [15:0]    div_eff;
    logic [31:0]    count_ext;
    logic           unused_ok;

    assign word_addr = IOBUS_ADDR[31:2];
    assign base_word = BASE_ADDR[31:2];
    assign sel_data  = (word_addr == base_word);
    assign sel_stat  = (word_addr == base_word + 30'd1);
    assign sel_div   = (word_addr == base_word + 30'd2);
    assign wr_data   = IOBUS_WR && sel_data;
    assign wr_stat   = IOBUS_WR && sel_stat;
    assign wr_div    = IOBUS_WR && sel_div;
    assign unused_ok = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign tc        = (div_cnt_q == 16'd0);
    // bit_len holds D-1 so the down-counter terminates on zero; DIV=0 acts as 1
    assign div_eff   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
    assign count_ext = 32'(count_q);

    // A push into a full FIFO is still accepted when the FSM pops on the same edge
    assign push      = wr_data && (!full || pop);

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overrun_d = overrun_q;
        if (wr_stat)
            overrun_d = 1'b0;
        else if (wr_data && !push)
            overrun_d = 1'b1;
        div_d     = wr_div ? IOBUS_OUT[15:0] : div_q;
    end

`ifdef UART_TX_IRQ_EN
    always_comb begin
        irq_en_d = wr_stat ? IOBUS_OUT[8] : irq_en_q;
        intr_d   = irq_en_q && !(wr_stat && !IOBUS_OUT[8]) && empty
                   && (state_q == S_IDLE) && !wr_data;
    end
`else
    always_comb begin
        irq_en_d = 1'b0;
        intr_d   = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_START;
            S_START: if (tc) state_d = S_DATA;
            S_DATA:  if (tc && bit_cnt_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (tc) state_d = empty ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        pop       = 1'b0;
        tx_d      = tx_q;
        shift_d   = shift_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        bit_len_d = bit_len_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_d      = 1'b0;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_len_d = div_eff;
                    div_cnt_d = div_eff;
                    bit_cnt_d = 3'd0;
                end
            end
            S_START: begin
                if (tc) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    div_cnt_d = bit_len_q;
                    bit_cnt_d = 3'd0;
                end else begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tc) begin
                    div_cnt_d = bit_len_q;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (tc) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        tx_d      = 1'b0;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_len_d = div_eff;
                        div_cnt_d = div_eff;
                        bit_cnt_d = 3'd0;
                    end else begin
                        tx_d      = 1'b1;
                        div_cnt_d = 16'd0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= IOBUS_OUT[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b0;
            intr_q    <= 1'b0;
            div_q     <= 16'(CLKS_PER_BIT);
            bit_len_q <= 16'd0;
            div_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            intr_q    <= intr_d;
            div_q     <= div_d;
            bit_len_q <= bit_len_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        IOBUS_IN = 32'd0;
        if (sel_stat)
            IOBUS_IN = {23'd0, irq_en_q, count_ext[3:0], overrun_q,
                        (state_q != S_IDLE), full, empty};
        else if (sel_div)
            IOBUS_IN = {16'd0, div_q};
    end

    assign TX   = tx_q;
    assign INTR = intr_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx: random bytes/divisors checked against a bit-stream model.
module tb_iobus_uart_tx;

    localparam logic [31:0] BASE = 32'h1100_0100;

`ifdef UART_TX_IRQ_EN
    localparam logic EXP_IRQ = 1'b1;
`else
    localparam logic EXP_IRQ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] iobus_in;
    logic        tx;
    logic        intr;

    int   checks = 0;
    int   errors = 0;
    logic exp_stream[$];
    int   idx;
    bit   chk_on = 0;

    iobus_uart_tx dut (
        .CLK        (clk),
        .RST        (rst),
        .IOBUS_ADDR (iobus_addr),
        .IOBUS_OUT  (iobus_out),
        .IOBUS_WR   (iobus_wr),
        .IOBUS_IN   (iobus_in),
        .TX         (tx),
        .INTR       (intr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; when armed, compare TX against the next expected line sample
    task automatic cyc();
        @(posedge clk);
        #1;
        if (chk_on) begin
            idx++;
            if (idx >= 0 && idx < int'(exp_stream.size()))
                chk($sformatf("tx[%0d]", idx), {31'd0, tx}, {31'd0, exp_stream[idx]});
        end
    endtask

    task automatic wr_bus(input logic [31:0] off, input logic [31:0] data);
        iobus_addr = BASE + off;
        iobus_out  = data;
        iobus_wr   = 1'b1;
        cyc();
        iobus_wr   = 1'b0;
        iobus_addr = 32'd0;
        iobus_out  = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        iobus_addr = BASE + off;
        #1;
        chk(tag, iobus_in, exp);
        iobus_addr = 32'd0;
    endtask

    // Expected line: per byte, start 0, 8 data bits LSB first, stop 1, each D cycles; then one idle sample
    task automatic build_stream(input logic [7:0] bytes[$], input int d);
        exp_stream.delete();
        foreach (bytes[n]) begin
            for (int k = 0; k < 10; k++) begin
                logic v;
                if (k == 0)      v = 1'b0;
                else if (k == 9) v = 1'b1;
                else             v = bytes[n][k-1];
                repeat (d) exp_stream.push_back(v);
            end
        end
        exp_stream.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] bytes[$], input int div_val, input int mid_div);
        int d;
        d = (div_val == 0) ? 1 : div_val;
        chk_on = 0;
        wr_bus(32'd8, 32'(div_val));
        build_stream(bytes, d);
        idx    = -2;
        chk_on = 1;
        foreach (bytes[n]) wr_bus(32'd0, {24'd0, bytes[n]});
        if (mid_div >= 0) begin
            repeat (2) cyc();
            wr_bus(32'd8, 32'(mid_div));
        end
        while (idx < int'(exp_stream.size()) - 1) cyc();
        chk_on = 0;
    endtask

    initial begin
        logic [7:0] q[$];
        int n, d;

        rst = 1'b1; iobus_addr = 32'd0; iobus_out = 32'd0; iobus_wr = 1'b0;
        repeat (2) cyc();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_intr", {31'd0, intr}, 32'd0);
        rd_chk("rst_status", 32'd4, 32'h1);
        rd_chk("rst_div", 32'd8, 32'd868);
        rst = 1'b0;
        cyc();

        // Known frame at D=4
        q = '{8'hA5};
        send(q, 4, -1);
        rd_chk("a5_status", 32'd4, 32'h1);

        // Back-to-back frames: stream model has no gap
        q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send(q, 2, -1);
        rd_chk("b2b_status", 32'd4, 32'h1);

        // DIV=0 acts as 1
        q = '{8'($urandom), 8'($urandom)};
        send(q, 0, -1);
        rd_chk("div0_status", 32'd4, 32'h1);

        // Mid-frame DIV write only affects later frames
        q = '{8'($urandom)};
        send(q, 3, 7);
        rd_chk("mid_div_rd", 32'd8, 32'd7);

        for (int it = 0; it < 4; it++) begin
            q.delete();
            n = $urandom_range(1, 4);
            d = $urandom_range(1, 6);
            repeat (n) q.push_back(8'($urandom));
            send(q, d, -1);
            rd_chk($sformatf("rand%0d_status", it), 32'd4, 32'h1);
        end

        wr_bus(32'd8, 32'h0000_1234);
        rd_chk("div_rd", 32'd8, 32'h0000_1234);
        rd_chk("unmapped_rd", 32'd12, 32'd0);
        rd_chk("data_rd", 32'd0, 32'd0);

        // Fill FIFO at slow baud; first byte pops so eight remain
        wr_bus(32'd8, 32'd100);
        repeat (9) wr_bus(32'd0, {24'd0, 8'($urandom)});
        rd_chk("full_status", 32'd4, 32'h86);
        wr_bus(32'd0, 32'h5A);
        rd_chk("overrun_status", 32'd4, 32'h8E);
        wr_bus(32'd4, 32'hFFFF_FEFF);
        rd_chk("overrun_clr", 32'd4, 32'h86);

        // Reset while shifting data bits
        repeat (150) cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        rd_chk("midrst_status", 32'd4, 32'h1);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("post_rst_tx", {31'd0, tx}, 32'd1);
        end
        rd_chk("post_rst_status", 32'd4, 32'h1);
        rd_chk("post_rst_div", 32'd8, 32'd868);

        // Interrupt on completion
        wr_bus(32'd4, 32'h100);
        rd_chk("irq_en_status", 32'd4, {23'd0, EXP_IRQ, 8'h01});
        q = '{8'($urandom)};
        send(q, 2, -1);
        chk("intr_at_idle", {31'd0, intr}, 32'd0);
        cyc();
        chk("intr_after_idle", {31'd0, intr}, {31'd0, EXP_IRQ});
        wr_bus(32'd0, {24'd0, 8'($urandom)});
        chk("intr_data_wr", {31'd0, intr}, 32'd0);
        repeat (25) cyc();
        chk("intr_rearm", {31'd0, intr}, {31'd0, EXP_IRQ});
        wr_bus(32'd4, 32'd0);
        chk("intr_irq_clr", {31'd0, intr}, 32'd0);
        rd_chk("final_status", 32'd4, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
